// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard scheduler.
// FSM encodings and register-select geometry.
package hazard_pkg;

  localparam int REG_SEL_W = 3;
  localparam int NUM_REGS  = 8;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  typedef struct packed {
    logic                 v;
    logic [REG_SEL_W-1:0] sel;
  } entry_t;

endpackage

// File: rtl/hazard_stall_ctrl_pipe.sv
// In-flight destination tracker for the EX..MEM stages.
// Produces a per-register busy mask and an all-empty flag.
module inflight_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_v,
  input  logic [REG_SEL_W-1:0] load_sel,
  input  logic                 flush,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 empty
);

  entry_t pipe_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= '{v: load_v, sel: load_sel};
      // a flushed EX occupant never reaches MEM
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= (i == 1 && flush) ? '0 : pipe_q[i-1];
      end
    end
  end

  always_comb begin
    busy_vec = '0;
    empty    = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_q[i].v) begin
        busy_vec[pipe_q[i].sel] = 1'b1;
        empty                   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Decode-stage issue/stall scheduler with flush squash
// and halt drain sequencing.
module hazard_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_SEL_W-1:0] id_rs_sel,
  input  logic                 id_rs_used,
  input  logic [REG_SEL_W-1:0] id_rt_sel,
  input  logic                 id_rt_used,
  input  logic                 id_wr_en,
  input  logic [REG_SEL_W-1:0] id_wr_sel,
  input  logic                 id_dump,
  input  logic                 flush,
  output logic                 stall,
  output logic                 issue,
  output logic [NUM_REGS-1:0]  busy_vec,
  output logic                 drained,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic                 err
);

  state_t state_q, state_d;
  logic   run;
  logic   hazard;
  logic   empty;

  inflight_pipe #(.DEPTH(DEPTH)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .load_v   (issue & id_wr_en & ~id_dump),
    .load_sel (id_wr_sel),
    .flush    (flush),
    .busy_vec (busy_vec),
    .empty    (empty)
  );

  assign run    = (state_q == RUN);
  assign hazard = id_valid
                & ((id_rs_used & busy_vec[id_rs_sel])
                 | (id_rt_used & busy_vec[id_rt_sel]));
  assign stall  = hazard & ~flush & run;
  assign issue  = id_valid & ~hazard & ~flush & run;
  assign drained = (state_q == HALTED);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:    if (issue & id_dump) state_d = DRAIN;
      // a flush means the HALT was on a wrong path
      DRAIN:  if (flush) state_d = RUN;
              else if (empty) state_d = HALTED;
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      stall_cnt <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (stall && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (drained && id_valid) begin
        err <= 1'b1;
      end
    end
  end

endmodule
